// File: rtl/hsi_sched_pkg.sv
// hsi_sched_pkg: source indices, scheduler states and helpers shared by the HSI tx scheduler
package hsi_sched_pkg;
  localparam int N_SRC = 4;
  localparam logic [1:0] SRC_BTC = 2'd0;
  localparam logic [1:0] SRC_CCW = 2'd1;
  localparam logic [1:0] SRC_SR = 2'd2;
  localparam logic [1:0] SRC_TM = 2'd3;
  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_RESP, GAP} state_t;
  function automatic logic [N_SRC-1:0] src_onehot(input logic [1:0] i);
    return {{(N_SRC-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/hsi_tx_sched_if.sv
// hsi_tx_sched_if: requester handshake and frame-link signals of the tx scheduler
interface hsi_tx_sched_if;
  import hsi_sched_pkg::*;
  logic [N_SRC-1:0] req, grant, ack, repeat_req, fail;
  logic tx_start, tx_done, rx_ok, rx_err;
  logic [1:0] tx_sel;
  modport master (input req, tx_done, rx_ok, rx_err, output grant, ack, repeat_req, fail, tx_start, tx_sel);
  modport slave (output req, tx_done, rx_ok, rx_err, input grant, ack, repeat_req, fail, tx_start, tx_sel);
endinterface

// File: rtl/hsi_prio_enc.sv
// hsi_prio_enc: fixed-priority encoder, lowest index wins
module hsi_prio_enc
  import hsi_sched_pkg::*;
(
  input  logic [N_SRC-1:0] v,
  output logic [N_SRC-1:0] onehot,
  output logic [1:0]       idx
);
  always_comb begin
    idx = v[0] ? SRC_BTC : v[1] ? SRC_CCW : v[2] ? SRC_SR : SRC_TM;
    onehot = (v != '0) ? src_onehot(idx) : '0;
  end
endmodule

// File: rtl/hsi_tx_sched.sv
// hsi_tx_sched: shares the HSI command frame slot between BTC/CCW/SR/TM with timeout and retry
module hsi_tx_sched
  import hsi_sched_pkg::*;
#(
  parameter int BTC_PERIOD = 48000,
  parameter int RESP_TIMEOUT = 480,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           btc_en,
  hsi_tx_sched_if.master bus,
  output logic           btc_overrun,
  output logic           busy
);
  localparam int TW = $clog2(RESP_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(BTC_PERIOD);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic [1:0] sel, sel_n, win_idx;
  logic [N_SRC-1:0] grant, grant_n, ack, ack_n, rep, rep_n, fl, fail_n, pend, win_oh;
  logic start, start_n, redo, redo_n, btc_pend, btc_pend_n, ovr, ovr_n, btc_clr;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] retry, retry_n;
  logic [GW-1:0] gap, gap_n;
  logic [BW-1:0] btc_cnt, btc_cnt_n;
  logic timeout, can_retry, gap_end, tc, btc_busy, unused_req0;
  assign unused_req0 = bus.req[0];
  assign pend = {bus.req[3:1], btc_pend};
  assign timeout = timer == TW'(RESP_TIMEOUT - 1);
  assign can_retry = retry < RW'(MAX_RETRY);
  assign gap_end = gap == GW'(GAP_CYCLES - 1);
  assign tc = btc_en && btc_cnt == BW'(BTC_PERIOD - 1);
  assign btc_busy = state != IDLE && sel == SRC_BTC;
  assign busy = state != IDLE;
  assign bus.grant = grant;
  assign bus.ack = ack;
  assign bus.repeat_req = rep;
  assign bus.fail = fl;
  assign bus.tx_start = start;
  assign bus.tx_sel = sel;
  assign btc_overrun = ovr;
  hsi_prio_enc u_enc (.v(pend), .onehot(win_oh), .idx(win_idx));
  always_comb begin
    state_n = state;
    sel_n = sel;
    grant_n = grant;
    timer_n = timer;
    retry_n = retry;
    gap_n = gap;
    redo_n = redo;
    ack_n = '0;
    rep_n = '0;
    fail_n = '0;
    start_n = 1'b0;
    btc_clr = 1'b0;
    case (state)
      IDLE: if (en && pend != '0) begin
        state_n = START;
        sel_n = win_idx;
        grant_n = win_oh;
      end
      START: begin
        start_n = 1'b1;
        state_n = SEND;
      end
      // BTC is a broadcast: it completes on tx_done without a response phase
      SEND: if (bus.tx_done) begin
        state_n = sel == SRC_BTC ? GAP : WAIT_RESP;
        ack_n = sel == SRC_BTC ? grant : '0;
        btc_clr = sel == SRC_BTC;
        timer_n = '0;
      end
      WAIT_RESP: if (bus.rx_ok) begin
        state_n = GAP;
        ack_n = grant;
        retry_n = '0;
      end else if (bus.rx_err || timeout) begin
        state_n = GAP;
        redo_n = can_retry;
        rep_n = can_retry ? grant : '0;
        fail_n = can_retry ? '0 : grant;
        retry_n = can_retry ? retry + 1'b1 : '0;
      end else timer_n = timer + 1'b1;
      // a scheduled retransmission skips arbitration and en/req checks
      GAP: begin
        gap_n = gap_end ? '0 : gap + 1'b1;
        state_n = !gap_end ? GAP : redo ? START : IDLE;
        grant_n = gap_end && redo ? src_onehot(sel) : '0;
        redo_n = redo && !gap_end;
      end
      default: state_n = IDLE;
    endcase
    btc_cnt_n = (!btc_en || tc) ? '0 : btc_cnt + 1'b1;
    btc_pend_n = tc ? 1'b1 : (btc_clr || (!btc_en && !btc_busy)) ? 1'b0 : btc_pend;
    ovr_n = tc && btc_pend;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      grant <= '0;
      ack <= '0;
      rep <= '0;
      fl <= '0;
      start <= 1'b0;
      timer <= '0;
      retry <= '0;
      gap <= '0;
      redo <= 1'b0;
      btc_cnt <= '0;
      btc_pend <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      grant <= grant_n;
      ack <= ack_n;
      rep <= rep_n;
      fl <= fail_n;
      start <= start_n;
      timer <= timer_n;
      retry <= retry_n;
      gap <= gap_n;
      redo <= redo_n;
      btc_cnt <= btc_cnt_n;
      btc_pend <= btc_pend_n;
      ovr <= ovr_n;
    end
  end
endmodule

// File: tb/tb_hsi_tx_sched.sv
// tb_hsi_tx_sched: directed vector tables plus hand sequences for retry, collision and BTC overrun
module tb_hsi_tx_sched;
  logic clk, rst, en, btc_en, btc_overrun, busy;
  int total = 0;
  int passed = 0;
  typedef struct {
    int cyc;
    logic [3:0] req;
    logic done, ok, err;
    logic [3:0] grant, ack, rep;
    logic start;
    logic [1:0] sel;
    logic busy;
  } vec_t;
  vec_t vec[$];
  int pol[$];
  int expv[$];
  hsi_tx_sched_if bus ();
  hsi_tx_sched #(.BTC_PERIOD(100), .RESP_TIMEOUT(20), .MAX_RETRY(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .btc_en(btc_en), .bus(bus), .btc_overrun(btc_overrun), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic do_reset(input logic b);
    rst = 1'b1;
    en = 1'b1;
    btc_en = b;
    bus.req = '0;
    bus.tx_done = 1'b0;
    bus.rx_ok = 1'b0;
    bus.rx_err = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
  endtask
  task automatic add(input int c, input logic [3:0] rq, input logic d, input logic o, input logic e,
                     input logic [3:0] g, input logic [3:0] a, input logic [3:0] r, input logic s,
                     input logic [1:0] sl, input logic b);
    vec_t t;
    t.cyc = c; t.req = rq; t.done = d; t.ok = o; t.err = e;
    t.grant = g; t.ack = a; t.rep = r; t.start = s; t.sel = sl; t.busy = b;
    vec.push_back(t);
  endtask
  task automatic run_table(input string tag, input logic b);
    int r = 0;
    do_reset(b);
    for (int c = 0; r < vec.size() && c < 400; c++) begin
      bus.tx_done = 1'b0;
      bus.rx_ok = 1'b0;
      bus.rx_err = 1'b0;
      if (vec[r].cyc == c) begin
        bus.req = vec[r].req;
        bus.tx_done = vec[r].done;
        bus.rx_ok = vec[r].ok;
        bus.rx_err = vec[r].err;
        chk($sformatf("%s_c%0d_grant", tag, c), bus.grant, vec[r].grant);
        chk($sformatf("%s_c%0d_ack", tag, c), bus.ack, vec[r].ack);
        chk($sformatf("%s_c%0d_rep", tag, c), bus.repeat_req, vec[r].rep);
        chk($sformatf("%s_c%0d_start", tag, c), bus.tx_start, vec[r].start);
        chk($sformatf("%s_c%0d_sel", tag, c), bus.tx_sel, vec[r].sel);
        chk($sformatf("%s_c%0d_busy", tag, c), busy, vec[r].busy);
        r++;
      end
      tick;
    end
    chk({tag, "_rows"}, r, vec.size());
    vec.delete();
  endtask
  task automatic run_sr(input string tag);
    int last_start = -1000, last_done = -1000, n = 0, p, starts = 0;
    logic [2:0] ev;
    do_reset(1'b0);
    bus.req = 4'b0100;
    for (int c = 0; c < 150; c++) begin
      if (bus.tx_start) begin
        last_start = c;
        starts++;
      end
      ev = {bus.fail[2], bus.repeat_req[2], bus.ack[2]};
      if (ev != 3'b000) begin
        p = n < pol.size() ? pol[n] : 0;
        chk($sformatf("%s_evt%0d", tag, n), ev, n < expv.size() ? expv[n] : 0);
        chk($sformatf("%s_lat%0d", tag, n), c - last_done, p == 0 ? 21 : 3);
        n++;
        if (ev == 3'b100) bus.req = '0;
      end
      p = n < pol.size() ? pol[n] : 0;
      bus.tx_done = c == last_start + 3;
      if (bus.tx_done) last_done = c;
      bus.rx_err = c == last_done + 2 && p != 0;
      bus.rx_ok = c == last_done + 2 && p == 2;
      tick;
    end
    chk({tag, "_events"}, n, expv.size());
    chk({tag, "_starts"}, starts, expv.size());
    pol.delete();
    expv.delete();
  endtask
  task automatic test_reset;
    logic any = 1'b0;
    do_reset(1'b0);
    bus.req = 4'b0100;
    tick;
    tick;
    chk("rst_pre_start", bus.tx_start, 1);
    rst = 1'b1;
    tick;
    chk("rst_grant", bus.grant, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_sel", bus.tx_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {bus.ack, bus.repeat_req, bus.fail, 3'b000, btc_overrun}, 0);
    tick;
    tick;
    rst = 1'b0;
    bus.req = '0;
    for (int c = 0; c < 30; c++) begin
      any = any | (|{bus.ack, bus.repeat_req, bus.fail, bus.tx_start, bus.grant});
      tick;
    end
    chk("rst_silent", any, 0);
  endtask
  task automatic test_en;
    do_reset(1'b0);
    en = 1'b0;
    bus.req = 4'b0010;
    repeat (5) tick;
    chk("en0_grant", bus.grant, 0);
    chk("en0_busy", busy, 0);
    en = 1'b1;
    tick;
    tick;
    chk("en1_grant", bus.grant, 4'b0010);
  endtask
  task automatic test_overrun;
    int ovr_cnt = 0, ovr_c = -1, st = 0, ak = 0, ak_c = -1;
    do_reset(1'b1);
    for (int c = 0; c < 300; c++) begin
      if (btc_overrun) begin
        ovr_cnt++;
        if (ovr_c < 0) ovr_c = c;
      end
      if (bus.tx_start) st++;
      if (bus.ack[0]) begin
        ak++;
        ak_c = c;
      end
      if (c == 101) chk("ovr_grant_btc", bus.grant, 4'b0001);
      if (c == 150) chk("ovr_grant_held", bus.grant, 4'b0001);
      if (c == 290) chk("ovr_idle_busy", busy, 0);
      bus.tx_done = c == 260;
      tick;
    end
    bus.tx_done = 1'b0;
    chk("ovr_first", ovr_c, 200);
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_starts", st, 1);
    chk("ovr_acks", ak, 1);
    chk("ovr_ack_cycle", ak_c, 261);
  endtask
  initial begin
    test_reset();
    test_en();
    // CCW then TM, second transaction ends with an rx_ok/rx_err collision
    add(0, 4'b1010, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0);
    add(1, 4'b1010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(2, 4'b1010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 1, 2'd1, 1);
    add(3, 4'b1010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(10, 4'b1010, 1, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(15, 4'b1010, 0, 1, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(16, 4'b1000, 0, 0, 0, 4'h2, 4'h2, 4'h0, 0, 2'd1, 1);
    add(17, 4'b1000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd1, 1);
    add(20, 4'b1000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd1, 0);
    add(21, 4'b1000, 0, 0, 0, 4'h8, 4'h0, 4'h0, 0, 2'd3, 1);
    add(22, 4'b1000, 0, 0, 0, 4'h8, 4'h0, 4'h0, 1, 2'd3, 1);
    add(30, 4'b1000, 1, 0, 0, 4'h8, 4'h0, 4'h0, 0, 2'd3, 1);
    add(33, 4'b1000, 0, 1, 1, 4'h8, 4'h0, 4'h0, 0, 2'd3, 1);
    add(34, 4'b0000, 0, 0, 0, 4'h8, 4'h8, 4'h0, 0, 2'd3, 1);
    add(35, 4'b0000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd3, 1);
    add(38, 4'b0000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd3, 0);
    run_table("arb", 1'b0);
    // BTC becomes pending while CCW waits for its response
    add(0, 4'b0000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0);
    add(90, 4'b0010, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0);
    add(91, 4'b0010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(92, 4'b0010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 1, 2'd1, 1);
    add(95, 4'b1010, 1, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(100, 4'b1010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(101, 4'b1010, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(105, 4'b1010, 0, 1, 0, 4'h2, 4'h0, 4'h0, 0, 2'd1, 1);
    add(106, 4'b1000, 0, 0, 0, 4'h2, 4'h2, 4'h0, 0, 2'd1, 1);
    add(111, 4'b1000, 0, 0, 0, 4'h1, 4'h0, 4'h0, 0, 2'd0, 1);
    add(112, 4'b1000, 0, 0, 0, 4'h1, 4'h0, 4'h0, 1, 2'd0, 1);
    add(115, 4'b1000, 1, 0, 0, 4'h1, 4'h0, 4'h0, 0, 2'd0, 1);
    add(116, 4'b1000, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0, 2'd0, 1);
    add(117, 4'b1000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1);
    add(121, 4'b1000, 0, 0, 0, 4'h8, 4'h0, 4'h0, 0, 2'd3, 1);
    add(122, 4'b1000, 0, 0, 0, 4'h8, 4'h0, 4'h0, 1, 2'd3, 1);
    run_table("btc", 1'b1);
    // SR with no responses: two repeats then fail (codes: 1 ack, 2 repeat, 4 fail)
    pol = '{0, 0, 0};
    expv = '{2, 2, 4};
    run_sr("tmo");
    // err, then ok+err collision, then retry count must restart from zero
    pol = '{1, 2, 1, 1, 1};
    expv = '{2, 1, 2, 2, 4};
    run_sr("coll");
    test_overrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
